force_cache_accumulator: RTL and testbench

// Consumer end of the PE force-output interface. Takes the NUM_FILTER force-buffer heads (data + valid), arbitrates one per cycle, pops the winner with write_success,
// and accumulates its fp32 force into a per-particle force cache. After the phase it exposes the cache through a read port, then clears it on request.

---
 rtl/force_cache_accumulator.sv | 220 ++++++++++++++++++++++
 tb/tb_force_cache_accumulator.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/force_cache_accumulator.sv
// Force cache accumulator: round-robin pops of force-buffer heads,
// fp32 read-modify-write into a per-particle cache, then read-out.
module force_cache_accumulator #(
   parameter int DATA_WIDTH         = 32,
   parameter int PARTICLE_ID_WIDTH  = 7,
   parameter int NUM_FILTER         = 7,
   parameter int FORCE_BUFFER_WIDTH = 3*DATA_WIDTH+PARTICLE_ID_WIDTH+1,
   parameter int ADD_LATENCY        = 3
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [NUM_FILTER*FORCE_BUFFER_WIDTH-1:0] force_data_in,
   input  logic [NUM_FILTER-1:0]                    force_valid,
   output logic [NUM_FILTER-1:0]                    write_success,
   input  logic                                     accum_done,
   input  logic                                     clear_cache,
   input  logic                                     rd_en,
   input  logic [PARTICLE_ID_WIDTH-1:0]             rd_addr,
   output logic [3*DATA_WIDTH-1:0]                  rd_force,
   output logic                                     rd_valid,
   output logic                                     cache_ready,
   output logic                                     busy
);

   localparam int FW    = 3*DATA_WIDTH;
   localparam int PW    = PARTICLE_ID_WIDTH;
   localparam int FBW   = FORCE_BUFFER_WIDTH;
   localparam int L     = ADD_LATENCY;
   localparam int DEPTH = 2**PW;
   localparam int RRW   = (NUM_FILTER > 1) ? $clog2(NUM_FILTER) : 1;

   typedef enum logic [1:0] {S_CLEAR, S_ACCUM, S_FLUSH, S_READY} state_t;

   state_t                r_state, w_next;
   logic [PW-1:0]         r_sweep;
   logic [RRW-1:0]        r_rr, w_rr_nxt;
   logic [L:0]            r_v;
   logic [PW-1:0]         r_pid [L+1];
   logic [FW-1:0]         r_dat [L+1];
   logic [FW-1:0]         r_cq;
   logic [FW-1:0]         r_cache [DEPTH];
   logic [FW-1:0]         w_dsum [1:L];
   logic [FW-1:0]         w_sum, w_wb, w_cdat;
   logic [PW-1:0]         w_cpid;
   logic [PW-1:0]         w_pid [NUM_FILTER];
   logic [NUM_FILTER-1:0] w_haz, w_elig, w_gnt, w_flags;
   logic                  w_any, w_unused;

   // fp32 add, round-to-nearest-even, denormal inputs/outputs flushed to zero
   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
      logic        sr, swp, up;
      logic [7:0]  e1, ed;
      logic [26:0] ma, mb, mx, msk;
      logic [27:0] sm;
      logic [24:0] rn;
      logic [9:0]  er;
      logic [4:0]  lz;
      logic [31:0] r;
      r = '0; sr = 1'b0; up = 1'b0; e1 = '0; ed = '0;
      ma = '0; mb = '0; mx = '0; msk = '0;
      sm = '0; rn = '0; er = '0; lz = '0;
      swp = a[30:0] < b[30:0];
      if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
         if ((a[30:23] == 8'hFF && a[22:0] != 0) ||
             (b[30:23] == 8'hFF && b[22:0] != 0) ||
             (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a[31] != b[31]))
            r = 32'h7FC0_0000;
         else if (a[30:23] == 8'hFF)
            r = a;
         else
            r = b;
      end else if (a[30:23] == 8'd0 && b[30:23] == 8'd0) begin
         r = {a[31] & b[31], 31'd0};
      end else if (a[30:23] == 8'd0) begin
         r = b;
      end else if (b[30:23] == 8'd0) begin
         r = a;
      end else begin
         sr = swp ? b[31] : a[31];
         e1 = swp ? b[30:23] : a[30:23];
         ed = swp ? b[30:23] - a[30:23] : a[30:23] - b[30:23];
         ma = swp ? {1'b1, b[22:0], 3'b000} : {1'b1, a[22:0], 3'b000};
         mb = swp ? {1'b1, a[22:0], 3'b000} : {1'b1, b[22:0], 3'b000};
         if (ed > 8'd26) begin
            mx = 27'd1;
         end else begin
            msk = (27'd1 << ed) - 27'd1;
            mx  = (mb >> ed) | {26'd0, |(mb & msk)};
         end
         er = {2'b00, e1};
         if (a[31] == b[31]) begin
            sm = {1'b0, ma} + {1'b0, mx};
            if (sm[27]) begin
               sm = {1'b0, sm[27:2], sm[1] | sm[0]};
               er = er + 10'd1;
            end
         end else begin
            sm = {1'b0, ma} - {1'b0, mx};
            for (int i = 0; i < 27; i++)
               if (sm[i]) lz = 5'(26 - i);
            sm = sm << lz;
            er = er - {5'd0, lz};
         end
         if (sm == '0) begin
            r = '0;
         end else if (er[9] || er == 10'd0) begin
            r = {sr, 31'd0};
         end else begin
            up = sm[2] & (sm[1] | sm[0] | sm[3]);
            rn = {1'b0, sm[26:3]} + {24'd0, up};
            if (rn[24]) begin
               rn = rn >> 1;
               er = er + 10'd1;
            end
            if (er >= 10'd255) r = {sr, 8'hFF, 23'd0};
            else               r = {sr, er[7:0], rn[22:0]};
         end
      end
      return r;
   endfunction

   always_comb begin
      for (int i = 0; i < NUM_FILTER; i++) begin
         w_pid[i]   = force_data_in[i*FBW+FW +: PW];
         w_flags[i] = force_data_in[i*FBW+FBW-1];
         w_haz[i]   = 1'b0;
         for (int k = 0; k <= L; k++)
            if (r_v[k] && r_pid[k] == w_pid[i]) w_haz[i] = 1'b1;
      end
      w_elig = force_valid & ~w_haz;
   end

   assign w_unused = ^w_flags;

   // r_rr holds the first index to search this cycle
   always_comb begin
      int j;
      j        = 0;
      w_gnt    = '0;
      w_any    = 1'b0;
      w_cpid   = '0;
      w_cdat   = '0;
      w_rr_nxt = r_rr;
      for (int k = 0; k < NUM_FILTER; k++) begin
         j = int'(r_rr) + k;
         if (j >= NUM_FILTER) j = j - NUM_FILTER;
         if (!w_any && r_state == S_ACCUM && w_elig[j]) begin
            w_any    = 1'b1;
            w_gnt[j] = 1'b1;
            w_cpid   = w_pid[j];
            w_cdat   = force_data_in[j*FBW +: FW];
            w_rr_nxt = (j == NUM_FILTER-1) ? '0 : RRW'(j + 1);
         end
      end
   end

   assign write_success = w_gnt;

   always_comb begin
      w_sum = {fadd(r_cq[2*DATA_WIDTH +: DATA_WIDTH], r_dat[1][2*DATA_WIDTH +: DATA_WIDTH]),
               fadd(r_cq[DATA_WIDTH +: DATA_WIDTH],   r_dat[1][DATA_WIDTH +: DATA_WIDTH]),
               fadd(r_cq[0 +: DATA_WIDTH],            r_dat[1][0 +: DATA_WIDTH])};
      w_dsum[1] = w_sum;
      for (int k = 2; k <= L; k++)
         w_dsum[k] = r_dat[k];
      w_wb = w_dsum[L];
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_CLEAR: if (&r_sweep)     w_next = S_ACCUM;
         S_ACCUM: if (accum_done)   w_next = S_FLUSH;
         S_FLUSH: if (r_v == '0)    w_next = S_READY;
         S_READY: if (clear_cache)  w_next = S_CLEAR;
         default:                   w_next = S_CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (r_state == S_CLEAR) r_cache[r_sweep]  <= '0;
      else if (r_v[L])        r_cache[r_pid[L]] <= w_wb;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_CLEAR;
         r_sweep  <= '0;
         r_rr     <= '0;
         r_v      <= '0;
         r_cq     <= '0;
         rd_force <= '0;
         rd_valid <= 1'b0;
         for (int k = 0; k <= L; k++) begin
            r_pid[k] <= '0;
            r_dat[k] <= '0;
         end
      end else begin
         r_state  <= w_next;
         r_sweep  <= (r_state == S_CLEAR) ? r_sweep + 1'b1 : '0;
         if (w_any) r_rr <= w_rr_nxt;
         r_v      <= {r_v[L-1:0], w_any};
         r_pid[0] <= w_cpid;
         r_dat[0] <= w_cdat;
         for (int k = 1; k <= L; k++)
            r_pid[k] <= r_pid[k-1];
         r_dat[1] <= r_dat[0];
         for (int k = 2; k <= L; k++)
            r_dat[k] <= w_dsum[k-1];
         r_cq     <= r_cache[r_pid[0]];
         rd_valid <= rd_en && r_state == S_READY;
         if (rd_en && r_state == S_READY) rd_force <= r_cache[rd_addr];
      end
   end

   assign cache_ready = r_state == S_READY;
   assign busy = r_state == S_CLEAR || r_state == S_FLUSH ||
                 (r_state == S_ACCUM && r_v != '0);

endmodule

// File: tb/tb_force_cache_accumulator.sv
// Directed bench for force_cache_accumulator: clear sweep, pops,
// round-robin, pid hazards, flush, read-out and mid-run reset.
module tb_force_cache_accumulator;

   localparam int DW  = 32;
   localparam int PW  = 7;
   localparam int NF  = 7;
   localparam int FBW = 3*DW+PW+1;

   logic              clk = 1'b0;
   logic              rst;
   logic [NF*FBW-1:0] force_data_in;
   logic [NF-1:0]     force_valid;
   logic [NF-1:0]     write_success;
   logic              accum_done, clear_cache, rd_en;
   logic [PW-1:0]     rd_addr;
   logic [3*DW-1:0]   rd_force;
   logic              rd_valid, cache_ready, busy;
   logic [FBW-1:0]    fw [NF];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   always_comb
      for (int i = 0; i < NF; i++)
         force_data_in[i*FBW +: FBW] = fw[i];

   force_cache_accumulator #(
      .DATA_WIDTH(DW), .PARTICLE_ID_WIDTH(PW), .NUM_FILTER(NF),
      .FORCE_BUFFER_WIDTH(FBW), .ADD_LATENCY(3)
   ) dut (
      .clk(clk), .rst(rst),
      .force_data_in(force_data_in), .force_valid(force_valid),
      .write_success(write_success),
      .accum_done(accum_done), .clear_cache(clear_cache),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_force(rd_force), .rd_valid(rd_valid),
      .cache_ready(cache_ready), .busy(busy)
   );

   function automatic logic [FBW-1:0] word(input int pid, input logic [31:0] fz,
                                           input logic [31:0] fy, input logic [31:0] fx);
      logic [PW-1:0] p;
      p = PW'(pid);
      return {1'b1, p, fz, fy, fx};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic rd(input int a, input logic [95:0] exp);
      rd_en   = 1'b1;
      rd_addr = PW'(a);
      tick();
      rd_en = 1'b0;
      chk($sformatf("rd_valid[%0d]", a), {95'd0, rd_valid}, 96'd1);
      chk($sformatf("rd_force[%0d]", a), rd_force, exp);
   endtask

   task automatic wait_ready();
      int k;
      k = 0;
      while (!cache_ready && k < 30) begin
         tick();
         k++;
      end
      chk("ready_timeout", {95'd0, cache_ready}, 96'd1);
   endtask

   task automatic wait_accum();
      int k;
      k = 0;
      while (busy && k < 300) begin
         tick();
         k++;
      end
      chk("accum_timeout", {95'd0, busy}, 96'd0);
   endtask

   initial begin
      logic [NF-1:0] ws, e, pend;
      int k, g, cyc, last, c0, c1;
      rst = 1'b0;
      force_valid = '0;
      accum_done = 1'b0;
      clear_cache = 1'b0;
      rd_en = 1'b0;
      rd_addr = '0;
      for (int i = 0; i < NF; i++) fw[i] = '0;

      #3;
      chk("rst_busy", {95'd0, busy}, 96'd1);
      chk("rst_ready", {95'd0, cache_ready}, 96'd0);
      chk("rst_ws", {89'd0, write_success}, 96'd0);
      chk("rst_rdv", {95'd0, rd_valid}, 96'd0);
      chk("rst_rdf", rd_force, 96'd0);
      #19;
      rst = 1'b1;
      k = 0;
      while (busy && k < 300) begin
         tick();
         k++;
      end
      chk("clear_len", k, 128);

      accum_done = 1'b1;
      tick();
      accum_done = 1'b0;
      wait_ready();
      for (int a = 0; a < 128; a++) rd(a, 96'd0);

      clear_cache = 1'b1;
      tick();
      clear_cache = 1'b0;
      wait_accum();

      fw[2] = word(5, 32'h40400000, 32'h40000000, 32'h3F800000);
      force_valid = 7'b0000100;
      @(negedge clk);
      chk("t2_ws", {89'd0, write_success}, {89'd0, 7'b0000100});
      tick();
      force_valid = '0;
      accum_done = 1'b1;
      tick();
      accum_done = 1'b0;
      wait_ready();
      rd(5, {32'h40400000, 32'h40000000, 32'h3F800000});

      rst = 1'b0;
      #1;
      chk("t3_rst_busy", {95'd0, busy}, 96'd1);
      tick();
      tick();
      rst = 1'b1;
      wait_accum();

      for (int i = 0; i < NF; i++)
         fw[i] = word(20 + i, 32'h3F000000, 32'h40000000, 32'h3F800000);
      force_valid = '1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         e = NF'(1 << (c % 7));
         chk($sformatf("t3_ws%0d", c), {89'd0, write_success}, {89'd0, e});
         tick();
      end
      force_valid = '0;

      fw[0] = word(9, 32'h0, 32'h0, 32'h3F800000);
      fw[1] = word(9, 32'h0, 32'h0, 32'h3F800000);
      c0 = 4; c1 = 4; cyc = 0; last = -100;
      force_valid = 7'b0000011;
      while ((c0 + c1) > 0 && cyc < 200) begin
         @(negedge clk);
         ws = write_success;
         if (ws != '0) begin
            chk("t4_onehot", $countones(ws), 1);
            chk("t4_gap", {95'd0, (cyc - last) >= 5}, 96'd1);
            last = cyc;
            if (ws[0]) c0--;
            if (ws[1]) c1--;
         end
         tick();
         cyc++;
         force_valid = {5'd0, c1 > 0, c0 > 0};
      end
      chk("t4_pops", c0 + c1, 0);

      fw[3] = word(40, 32'h0, 32'h0, 32'h3F800000);
      fw[4] = word(41, 32'h0, 32'h40000000, 32'h0);
      fw[5] = word(42, 32'h40400000, 32'h0, 32'h0);
      pend = 7'b0111000;
      force_valid = pend;
      g = 0; k = 0;
      while (g < 3 && k < 20) begin
         @(negedge clk);
         ws = write_success;
         if ((ws & pend) != '0) begin
            pend = pend & ~ws;
            g++;
         end
         if (g == 3) accum_done = 1'b1;
         tick();
         accum_done = 1'b0;
         force_valid = pend;
         k++;
      end
      chk("t5_grants", g, 3);
      k = 1;
      while (!cache_ready && k < 30) begin
         chk($sformatf("t5_busy%0d", k), {95'd0, busy}, 96'd1);
         tick();
         k++;
      end
      chk("t5_ready", {95'd0, cache_ready}, 96'd1);
      chk("t5_ready_after_wb", {95'd0, k >= 5}, 96'd1);
      accum_done = 1'b1;
      tick();
      accum_done = 1'b0;
      chk("ignore_done", {95'd0, cache_ready}, 96'd1);

      rd(5, 96'd0);
      for (int p = 20; p < 23; p++) rd(p, {32'h3F800000, 32'h40800000, 32'h40000000});
      for (int p = 23; p < 27; p++) rd(p, {32'h3F000000, 32'h40000000, 32'h3F800000});
      rd(9,  {32'h0, 32'h0, 32'h41000000});
      rd(40, {32'h0, 32'h0, 32'h3F800000});
      rd(41, {32'h0, 32'h40000000, 32'h0});
      rd(42, {32'h40400000, 32'h0, 32'h0});

      fw[6] = word(60, 32'h0, 32'h0, 32'h3F800000);
      force_valid = 7'b1000000;
      clear_cache = 1'b1;
      accum_done = 1'b1;
      tick();
      clear_cache = 1'b0;
      accum_done = 1'b0;
      chk("t6_clr_ready", {95'd0, cache_ready}, 96'd0);
      for (int j = 0; j < 128; j++) begin
         chk($sformatf("t6_clr_ws%0d", j), {89'd0, write_success}, 96'd0);
         tick();
      end
      @(negedge clk);
      chk("t6_grant", {89'd0, write_success}, {89'd0, 7'b1000000});
      clear_cache = 1'b1;
      tick();
      clear_cache = 1'b0;
      chk("t6_busy_inflight", {95'd0, busy}, 96'd1);
      chk("t6_ignore_clear", {95'd0, cache_ready}, 96'd0);
      rd_en = 1'b1;
      rd_addr = PW'(9);
      tick();
      rd_en = 1'b0;
      chk("t6_rdv_accum", {95'd0, rd_valid}, 96'd0);
      chk("t6_rdf_hold", rd_force, {32'h40400000, 32'h0, 32'h0});

      rst = 1'b0;
      #1;
      chk("t6_rst_ws", {89'd0, write_success}, 96'd0);
      chk("t6_rst_rdf", rd_force, 96'd0);
      tick();
      tick();
      rst = 1'b1;
      for (int j = 0; j < 128; j++) begin
         chk($sformatf("t6_rst_ws%0d", j), {89'd0, write_success}, 96'd0);
         if (j == 127) force_valid = '0;
         tick();
      end
      chk("t6_accum_idle", {95'd0, busy}, 96'd0);
      accum_done = 1'b1;
      tick();
      accum_done = 1'b0;
      wait_ready();
      for (int a = 0; a < 128; a++) rd(a, 96'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
